ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter that sends one command byte to the keyboard, for example 0xFF reset, 0xED set-LEDs or 0xF4 enable. It complements the existing PS/2 receive path.
- Sits next to the keyboard decoder inside game_play and shares the PS2_CLK/PS2_DATA inout pins.
- Drives those pins open-collector through active-high pull-low enables.
- Runs on the 100 MHz system clk and handles the full request-to-send sequence, ACK check and timeouts.

---
 rtl/ps2_host_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 11-edge frame, ACK check, timeouts.
// Optional macro PS2_TX_RETRY_EN adds one automatic retry after a NACK or timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int BIT_TIMEOUT    = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);
    localparam int CNT_MAX_A = (INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT;
    localparam int CNT_MAX   = (START_TIMEOUT > CNT_MAX_A) ? START_TIMEOUT : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_idx;
    logic [9:0]       r_frame;
    logic             r_ack_err;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_done;
    logic             r_timeout;
    logic             r_clk_meta, r_clk_sync, r_clk_prev;
    logic             r_data_meta, r_data_sync;
`ifdef PS2_TX_RETRY_EN
    logic             r_retry;
    logic             w_retry_next;
`endif

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_bit_idx_next;
    logic [3:0]       w_idx_inc;
    logic [9:0]       w_frame_next;
    logic             w_ack_err_next;
    logic             w_clk_oe_next;
    logic             w_data_oe_next;
    logic             w_done_next;
    logic             w_timeout_next;
    logic             w_end_ok;
    logic             w_end_tmo;
    logic             w_fall;

    // Two-flop synchronizers; reset to the idle (released) bus level so no false edge follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_i;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_i;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
    assign w_idx_inc = r_bit_idx + 4'd1;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_cnt_inc;
        w_bit_idx_next = r_bit_idx;
        w_frame_next   = r_frame;
        w_ack_err_next = r_ack_err;
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = r_data_oe;
        w_done_next    = 1'b0;
        w_timeout_next = 1'b0;
        w_end_ok       = 1'b0;
        w_end_tmo      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_retry_next   = r_retry;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next     = '0;
                w_data_oe_next = 1'b0;
                if (tx_valid) begin
                    w_frame_next   = {1'b1, ~^tx_data, tx_data};
                    w_ack_err_next = 1'b0;
                    w_clk_oe_next  = 1'b1;
                    w_state_next   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    w_retry_next   = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                w_clk_oe_next = 1'b1;
                if (r_cnt >= INH_LAST) begin
                    w_clk_oe_next  = 1'b0;
                    w_data_oe_next = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = S_RTS;
                end
            end
            S_RTS: begin
                if (w_fall) begin
                    w_data_oe_next = ~r_frame[0];
                    w_bit_idx_next = 4'd0;
                    w_cnt_next     = '0;
                    w_state_next   = S_DATA;
                end else if (r_cnt >= START_LAST) begin
                    w_end_tmo = 1'b1;
                end
            end
            S_DATA: begin
                if (w_fall) begin
                    // Frame bit 9 is the stop bit (1), so the line is released on edge 10.
                    w_data_oe_next = ~r_frame[w_idx_inc];
                    w_bit_idx_next = w_idx_inc;
                    w_cnt_next     = '0;
                    if (w_idx_inc == 4'd9) begin
                        w_state_next = S_ACK;
                    end
                end else if (r_cnt >= BIT_LAST) begin
                    w_end_tmo = 1'b1;
                end
            end
            S_ACK: begin
                w_data_oe_next = 1'b0;
                if (w_fall) begin
                    w_ack_err_next = r_data_sync;
                    w_cnt_next     = '0;
                    w_state_next   = S_WAIT_IDLE;
                end else if (r_cnt >= BIT_LAST) begin
                    w_end_tmo = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_sync && r_data_sync) begin
                    w_end_ok = 1'b1;
                end else if (r_cnt >= BIT_LAST) begin
                    w_end_tmo = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_end_ok || w_end_tmo) begin
            w_clk_oe_next  = 1'b0;
            w_data_oe_next = 1'b0;
            w_cnt_next     = '0;
            w_state_next   = S_IDLE;
`ifdef PS2_TX_RETRY_EN
            if (!r_retry && (w_end_tmo || r_ack_err)) begin
                w_retry_next   = 1'b1;
                w_ack_err_next = 1'b0;
                w_clk_oe_next  = 1'b1;
                w_state_next   = S_INHIBIT;
            end else begin
                w_done_next    = w_end_ok;
                w_timeout_next = w_end_tmo;
            end
`else
            w_done_next    = w_end_ok;
            w_timeout_next = w_end_tmo;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_frame   <= '0;
            r_ack_err <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_retry   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_frame   <= w_frame_next;
            r_ack_err <= w_ack_err_next;
            r_clk_oe  <= w_clk_oe_next;
            r_data_oe <= w_data_oe_next;
            r_done    <= w_done_next;
            r_timeout <= w_timeout_next;
`ifdef PS2_TX_RETRY_EN
            r_retry   <= w_retry_next;
`endif
        end
    end

    assign tx_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_done     = r_done;
    assign tx_ack_err  = r_ack_err;
    assign tx_timeout  = r_timeout;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames, ACKs/NACKs, stalls, and reset aborts.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH   = 40;
    localparam int ST    = 300;
    localparam int BT    = 120;
    localparam int CLK_P = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_ack_err, tx_timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;

    int n_checks = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_tmo = 0;
    int n_busy_gap = 0;

    // Open-collector bus with pull-ups: either side may pull a line low.
    assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_i = ~ps2_data_oe & dev_data;

    always #(CLK_P/2) clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (ST),
        .BIT_TIMEOUT   (BT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_ack_err (tx_ack_err),
        .tx_timeout (tx_timeout)
    );

    always @(posedge clk) begin
        #1;
        if (tx_done) n_done++;
        if (tx_timeout) n_tmo++;
        if (!busy && !tx_done && !tx_timeout) n_busy_gap++;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        $display("tx: sent byte 0x%02h", b);
    endtask

    // Device side: measure the inhibit, then produce n_edges clock pulses, capturing host bits on edges 1-10.
    task automatic dev_run(input int n_edges, input bit ack_low, output int inh_cnt,
                           output bit start_low, output logic [9:0] bits,
                           output time t_rel, output time t_fall);
        inh_cnt   = 0;
        start_low = 1'b0;
        bits      = '0;
        t_rel     = 0;
        t_fall    = 0;
        for (int i = 0; i < 50 && !ps2_clk_oe; i++) @(negedge clk);
        while (ps2_clk_oe && inh_cnt < 4 * INH) begin
            inh_cnt++;
            @(negedge clk);
        end
        t_rel     = $time;
        start_low = (ps2_data_i == 1'b0);
        repeat (5) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && ack_low) begin
                dev_data = 1'b0;
                repeat (3) @(negedge clk);
            end
            dev_clk = 1'b0;
            t_fall  = $time;
            repeat (10) @(negedge clk);
            if (e <= 10) bits[e-1] = ps2_data_i;
            dev_clk = 1'b1;
            if (e == 11) dev_data = 1'b1;
            else repeat (10) @(negedge clk);
        end
        $display("dev: inhibit=%0d start_low=%0b edges=%0d bits=%b", inh_cnt, start_low, n_edges, bits);
    endtask

    task automatic wait_result(input int limit, output bit got_done, output bit got_tmo,
                               output logic ack_err, output time t);
        got_done = 1'b0;
        got_tmo  = 1'b0;
        ack_err  = 1'bx;
        t        = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_done || tx_timeout) begin
                got_done = tx_done;
                got_tmo  = tx_timeout;
                ack_err  = tx_ack_err;
                t        = $time;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_timeout} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_in: got ready/busy/clk_oe/data_oe/done/tmo=%b want 100000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_timeout});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_out: got ready/busy/clk_oe/data_oe=%b want 1000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
        $display("reset: ready=%0b busy=%0b", tx_ready, busy);
    endtask

    task automatic test_ack_ok(input logic [7:0] b, input logic [9:0] exp_bits);
        int inh; bit sl, gd, gt; logic [9:0] bits; logic ae; time tr, tf, t;
        send(b);
        n_checks++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_%02h: got ready=%b busy=%b want ready=0 busy=1", b, tx_ready, busy);
        end
        dev_run(11, 1'b1, inh, sl, bits, tr, tf);
        wait_result(40, gd, gt, ae, t);
        n_checks++;
        if (inh != INH) begin
            n_fail++;
            $display("FAIL inhibit_len_%02h: got %0d want %0d", b, inh, INH);
        end
        n_checks++;
        if (sl !== 1'b1) begin
            n_fail++;
            $display("FAIL start_bit_%02h: got line high want low", b);
        end
        n_checks++;
        if (bits !== exp_bits) begin
            n_fail++;
            $display("FAIL frame_bits_%02h: got %b want %b", b, bits, exp_bits);
        end
        n_checks++;
        if (gd !== 1'b1 || gt !== 1'b0 || ae !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_ok_%02h: got done=%b tmo=%b ack_err=%b want 1 0 0", b, gd, gt, ae);
        end
        $display("ack_ok: byte=0x%02h done=%0b ack_err=%0b", b, gd, ae);
    endtask

    task automatic test_nack();
        int inh; bit sl, gd, gt; logic [9:0] bits; logic ae; time tr, tf, t;
        send(8'hF4);
        dev_run(11, 1'b0, inh, sl, bits, tr, tf);
        wait_result(40, gd, gt, ae, t);
        n_checks++;
        if (bits[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_F4: got %b want 0", bits[8]);
        end
        n_checks++;
        if (bits !== 10'h2F4) begin
            n_fail++;
            $display("FAIL frame_bits_F4: got %b want %b", bits, 10'h2F4);
        end
        n_checks++;
        if (gd !== 1'b1 || gt !== 1'b0 || ae !== 1'b1) begin
            n_fail++;
            $display("FAIL nack_F4: got done=%b tmo=%b ack_err=%b want 1 0 1", gd, gt, ae);
        end
        $display("nack: byte=0xF4 done=%0b ack_err=%0b", gd, ae);
    endtask

    task automatic test_start_timeout();
        int inh, d0; bit sl, gd, gt; logic [9:0] bits; logic ae; time tr, tf, t;
        longint dly;
        d0 = n_done;
        send(8'hFF);
        dev_run(0, 1'b0, inh, sl, bits, tr, tf);
        wait_result(ST + 50, gd, gt, ae, t);
        dly = longint'((t - tr) / CLK_P);
        n_checks++;
        if (gt !== 1'b1 || gd !== 1'b0) begin
            n_fail++;
            $display("FAIL start_tmo_pulse: got tmo=%b done=%b want 1 0", gt, gd);
        end
        n_checks++;
        if (dly != ST) begin
            n_fail++;
            $display("FAIL start_tmo_delay: got %0d cycles want %0d", dly, ST);
        end
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL start_tmo_release: got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe);
        end
        @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || tx_timeout !== 1'b0 || n_done != d0) begin
            n_fail++;
            $display("FAIL start_tmo_after: got ready=%b tmo=%b done_pulses=%0d want 1 0 0",
                     tx_ready, tx_timeout, n_done - d0);
        end
        $display("start_timeout: delay=%0d cycles", dly);
    endtask

    task automatic test_bit_timeout();
        int inh, d0; bit sl, gd, gt; logic [9:0] bits; logic ae; time tr, tf, t;
        longint dly;
        d0 = n_done;
        send(8'h00);
        dev_run(5, 1'b0, inh, sl, bits, tr, tf);
        wait_result(BT + 50, gd, gt, ae, t);
        dly = longint'((t - tf) / CLK_P);
        n_checks++;
        if (bits[4:0] !== 5'b00000) begin
            n_fail++;
            $display("FAIL bits_00: got %b want 00000", bits[4:0]);
        end
        n_checks++;
        if (gt !== 1'b1 || gd !== 1'b0) begin
            n_fail++;
            $display("FAIL bit_tmo_pulse: got tmo=%b done=%b want 1 0", gt, gd);
        end
        // Pin fall to FSM reaction is 2 sync cycles plus one to the registered pulse.
        n_checks++;
        if (dly != BT + 3) begin
            n_fail++;
            $display("FAIL bit_tmo_delay: got %0d cycles want %0d", dly, BT + 3);
        end
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || n_done != d0) begin
            n_fail++;
            $display("FAIL bit_tmo_release: got clk_oe=%b data_oe=%b done_pulses=%0d want 0 0 0",
                     ps2_clk_oe, ps2_data_oe, n_done - d0);
        end
        $display("bit_timeout: delay=%0d cycles from 5th edge", dly);
    endtask

    task automatic test_reset_mid_data();
        int inh, d0, t0; bit sl; logic [9:0] bits; time tr, tf;
        send(8'hED);
        dev_run(5, 1'b0, inh, sl, bits, tr, tf);
        n_checks++;
        if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_data_state: got data_oe=%b busy=%b want 1 1", ps2_data_oe, busy);
        end
        d0 = n_done;
        t0 = n_tmo;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ps2_data_oe !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL async_release: got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || n_done != d0 || n_tmo != t0) begin
            n_fail++;
            $display("FAIL after_reset: got ready=%b busy=%b done=%0d tmo=%0d want 1 0 0 0",
                     tx_ready, busy, n_done - d0, n_tmo - t0);
        end
        $display("reset_mid_data: released, ready=%0b", tx_ready);
        test_ack_ok(8'hED, 10'h3ED);
    endtask

`ifdef PS2_TX_RETRY_EN
    task automatic test_retry();
        int inh1, inh2, d0, g0; bit sl, gd, gt; logic [9:0] bits; logic ae; time tr, tf, t;
        d0 = n_done;
        send(8'hED);
        g0 = n_busy_gap;
        dev_run(11, 1'b0, inh1, sl, bits, tr, tf);
        dev_run(11, 1'b1, inh2, sl, bits, tr, tf);
        wait_result(40, gd, gt, ae, t);
        n_checks++;
        if (inh1 != INH || inh2 != INH) begin
            n_fail++;
            $display("FAIL retry_inhibits: got %0d,%0d want %0d,%0d", inh1, inh2, INH, INH);
        end
        n_checks++;
        if (gd !== 1'b1 || ae !== 1'b0 || n_done - d0 != 1) begin
            n_fail++;
            $display("FAIL retry_done: got done=%b ack_err=%b pulses=%0d want 1 0 1", gd, ae, n_done - d0);
        end
        n_checks++;
        if (n_busy_gap != g0) begin
            n_fail++;
            $display("FAIL retry_busy: got %0d idle cycles want 0", n_busy_gap - g0);
        end
        $display("retry: done=%0b ack_err=%0b", gd, ae);
    endtask
`endif

    initial begin
        test_reset();
        test_ack_ok(8'hED, 10'h3ED);
`ifdef PS2_TX_RETRY_EN
        test_retry();
`else
        test_nack();
        test_start_timeout();
        test_bit_timeout();
`endif
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
